// File: rtl/fir_seq_pkg.sv
// Shared definitions for the FIR frame sequencer.
//  - seq_state_t : sequencer FSM states
//  - DEF_*       : default datapath / frame geometry
//  - out_count() : number of framed outputs per frame for a given build
package fir_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_TAPS      = 32;
  localparam int DEF_FRAME_LEN = 256;

  // With the zero tail every accepted sample yields one output; without it
  // the first TAPS-1 accepts are swallowed by the FIR warm-up.
  function automatic int out_count(input bit flush_en, input int frame_len,
                                   input int taps);
    return flush_en ? frame_len : frame_len - (taps - 1);
  endfunction

endpackage

// File: rtl/fir_seq_ctr.sv
// Clearable, enabled up-counter with terminal-count flag.
//  clk, rst : clock, synchronous active-high reset
//  clr      : synchronous clear (dominates en)
//  en       : count one event
//  cnt      : current count
//  tc       : high while cnt == TERM_CNT-1, so (en & tc) marks the
//             TERM_CNT-th event
module fir_seq_ctr
  import fir_seq_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int TERM_CNT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TERM_CNT - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/fir_frame_sequencer.sv
// FIR frame sequencer: re-primes a TAPS-tap FIR at every frame start, feeds
// it FRAME_LEN accepted samples, hides warm-up outputs and delivers a framed
// (SOF/EOF), backpressured stream to the FFT stage.
//
// Build option: define FIR_SEQ_FLUSH_EN to append TAPS-1 zero samples after
// the frame (FLUSH state), giving FRAME_LEN outputs with EOF on the last zero.
// Without it the frame ends on the last accepted input with
// FRAME_LEN-(TAPS-1) outputs.
//
// Ports
//  clk, rst        clock, synchronous active-high reset
//  start, abort    frame start (IDLE only) / drop frame (wins over start)
//  busy            high outside IDLE
//  frame_done      one-cycle pulse after the last output of a frame
//  in_valid/in_ready/in_data         upstream sample port
//  fir_rst, fir_data_valid, fir_data drive the FIR
//  fir_valid, fir_d                  FIR warm-up complete / FIR result
//  out_valid/out_ready/out_data      framed output port
//  out_sof, out_eof                  first/last output, qualified by out_valid
module fir_frame_sequencer
  import fir_seq_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TAPS      = DEF_TAPS,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     frame_done,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     fir_rst,
  output logic                     fir_data_valid,
  output logic signed [DATA_W-1:0] fir_data,
  input  logic                     fir_valid,
  input  logic signed [DATA_W-1:0] fir_d,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_sof,
  output logic                     out_eof
);

`ifdef FIR_SEQ_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif
  localparam int OUT_N = out_count(FLUSH_EN, FRAME_LEN, TAPS);

  seq_state_t       state_q;
  logic             accept;
  logic             flush_pulse;
  logic             ctr_clr;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic             in_tc;
  logic             out_tc;

  // Once the FIR is warm, a sample may enter only if its result can leave
  // in the same cycle; during warm-up nothing comes out, so ignore out_ready.
  assign in_ready = (state_q == RUN) && (out_ready || !fir_valid);
  assign accept   = in_valid && in_ready;

  // Counters restart in IDLE and on abort so every frame begins from zero.
  assign ctr_clr = abort || (state_q == IDLE);

`ifdef FIR_SEQ_FLUSH_EN
  logic [CNT_W-1:0] flush_cnt;
  logic             flush_tc;
  logic             unused_cnt_bits;

  // Zero pulses are only issued when the downstream can take the result.
  assign flush_pulse = (state_q == FLUSH) && out_ready;

  fir_seq_ctr #(.CNT_W(CNT_W), .TERM_CNT(TAPS - 1)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (ctr_clr),
    .en  (flush_pulse),
    .cnt (flush_cnt),
    .tc  (flush_tc)
  );

  assign unused_cnt_bits = ^{in_cnt, flush_cnt};
`else
  logic unused_cnt_bits;

  assign flush_pulse     = 1'b0;
  assign unused_cnt_bits = ^in_cnt;
`endif

  fir_seq_ctr #(.CNT_W(CNT_W), .TERM_CNT(FRAME_LEN)) u_in_cnt (
    .clk (clk),
    .rst (rst),
    .clr (ctr_clr),
    .en  (accept),
    .cnt (in_cnt),
    .tc  (in_tc)
  );

  fir_seq_ctr #(.CNT_W(CNT_W), .TERM_CNT(OUT_N)) u_out_cnt (
    .clk (clk),
    .rst (rst),
    .clr (ctr_clr),
    .en  (out_valid),
    .cnt (out_cnt),
    .tc  (out_tc)
  );

  // Datapath towards the FIR is zero latency: the FIR result for this
  // sample appears on fir_d in the same cycle.
  assign fir_data_valid = accept || flush_pulse;
  assign fir_data       = (state_q == RUN) ? in_data : '0;
  assign fir_rst        = rst || (state_q == PRIME);

  assign out_valid = fir_data_valid && fir_valid;
  assign out_data  = fir_d;
  assign out_sof   = out_valid && (out_cnt == '0);
  assign out_eof   = out_valid && out_tc;

  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (abort) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:  if (start) state_q <= PRIME;
        PRIME: state_q <= RUN;
        RUN:   if (accept && in_tc) state_q <= FLUSH_EN ? FLUSH : DONE;
`ifdef FIR_SEQ_FLUSH_EN
        FLUSH: if (flush_pulse && flush_tc) state_q <= DONE;
`endif
        DONE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_frame_sequencer.sv
module tb_fir_frame_sequencer;

  localparam int DW    = 16;
  localparam int TAPS  = 32;
  localparam int FLEN  = 64;
`ifdef FIR_SEQ_FLUSH_EN
  localparam int NOUT  = 64;
  localparam int RST_AT = FLEN;
`else
  localparam int NOUT  = 33;
  localparam int RST_AT = 60;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic                 busy, frame_done;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 fir_rst, fir_data_valid;
  logic signed [DW-1:0] fir_data;
  logic                 fir_valid;
  logic signed [DW-1:0] fir_d;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [DW-1:0] out_data;
  logic                 out_sof, out_eof;

  int checks = 0;
  int failures = 0;
  int popped = 0;

  typedef struct {
    int d;
    bit sof;
    bit eof;
  } exp_t;
  exp_t exp_q[$];

  int coef[TAPS];
  int smp[FLEN];

  always #5 clk = ~clk;

  fir_frame_sequencer #(.DATA_W(DW), .TAPS(TAPS), .FRAME_LEN(FLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy),
    .frame_done(frame_done), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .fir_rst(fir_rst), .fir_data_valid(fir_data_valid),
    .fir_data(fir_data), .fir_valid(fir_valid), .fir_d(fir_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eof(out_eof)
  );

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // FIR attached to the sequencer: Q15 coefficients, warm-up after TAPS-1 samples.
  logic signed [DW-1:0] fir_tap[TAPS-1];
  int fir_cnt;

  always_ff @(posedge clk) begin
    if (fir_rst) begin
      fir_cnt <= 0;
      for (int i = 0; i < TAPS-1; i++) fir_tap[i] <= '0;
    end else if (fir_data_valid) begin
      if (fir_cnt < TAPS-1) fir_cnt <= fir_cnt + 1;
      fir_tap[0] <= fir_data;
      for (int i = 1; i < TAPS-1; i++) fir_tap[i] <= fir_tap[i-1];
    end
  end

  assign fir_valid = (fir_cnt >= TAPS-1);

  always_comb begin
    longint s;
    s = longint'(coef[0]) * longint'(fir_data);
    for (int k = 1; k < TAPS; k++) s += longint'(coef[k]) * longint'(fir_tap[k-1]);
    fir_d = DW'(sat16(s >>> 15));
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected frame output: output j is the full convolution at input
  // position j+TAPS-1 of the frame samples (zeros past the frame end).
  task automatic build_exp();
    exp_t e;
    exp_q.delete();
    popped = 0;
    for (int j = 0; j < NOUT; j++) begin
      int n;
      longint s;
      n = j + TAPS - 1;
      s = 0;
      for (int k = 0; k < TAPS; k++)
        if (n - k < FLEN) s += longint'(coef[k]) * longint'(smp[n-k]);
      e.d   = int'(sat16(s >>> 15));
      e.sof = (j == 0);
      e.eof = (j == NOUT - 1);
      exp_q.push_back(e);
    end
  endtask

  // Output compare: every presented output must be the next expected one.
  always @(posedge clk) begin
    exp_t e;
    #3;
    if (out_valid) begin
      chk("out_valid_needs_ready", out_ready, 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_sof", out_sof, e.sof);
        chk("out_eof", out_eof, e.eof);
        popped++;
      end
    end
  end

  task automatic reset_outputs_chk(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_fir_data_valid"}, fir_data_valid, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_sof"}, out_sof, 0);
    chk({tag, "_out_eof"}, out_eof, 0);
    chk({tag, "_fir_rst"}, fir_rst, 1);
  endtask

  // kind: 0 normal, 1 abort at acc==trig, 2 rst at acc==trig, 3 start while busy.
  // mode: 0 out_ready held high, 1 out_ready toggling every cycle.
  task automatic do_frame(input int mode, input int kind, input int trig);
    int acc, cyc, dones;
    bit fin, hit;
    acc = 0; cyc = 0; dones = 0; fin = 0; hit = 0;
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; #1;
    chk("prime_fir_rst", fir_rst, 1);
    chk("prime_busy", busy, 1);
    chk("prime_in_ready", in_ready, 0);
    while (!fin && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      out_ready = (mode == 0) ? 1'b1 : cyc[0];
      in_valid  = (acc < FLEN);
      in_data   = (acc < FLEN) ? DW'(smp[acc]) : '0;
      start     = (kind == 3 && acc == trig);
      if (kind == 1 && acc == trig) begin
        abort = 1'b1; in_valid = 1'b0; hit = 1; fin = 1;
      end
      if (kind == 2 && acc == trig) begin
        rst = 1'b1; hit = 1; fin = 1;
      end
      #1;
      if (!hit) begin
        if (frame_done) begin
          dones++;
          fin = 1;
        end
        if (acc < TAPS - 1) chk("warmup_in_ready", in_ready, 1);
        else if (acc < FLEN) chk("in_ready_follows_out_ready", in_ready, out_ready);
        else chk("in_ready_after_frame", in_ready, 0);
        if (in_valid && in_ready) begin
          chk("fir_data_valid", fir_data_valid, 1);
          chk("fir_data", fir_data, in_data);
          if (acc < TAPS - 1) chk("warmup_no_output", out_valid, 0);
          if (acc == TAPS - 1) chk("first_output_sof", out_valid && out_sof, 1);
          acc++;
        end
      end
    end
    if (!fin) chk("frame_timeout", 0, 1);
    if (kind == 2) begin
      @(posedge clk); #2;
      reset_outputs_chk("rst_mid_frame");
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      #1;
      chk("post_rst_fir_rst", fir_rst, 0);
    end else begin
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0; in_valid = 1'b0;
      #1;
      chk("end_busy", busy, 0);
      chk("end_in_ready", in_ready, 0);
      if (kind == 1) begin
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
          @(posedge clk); #2;
          chk("abort_no_done", frame_done, 0);
          chk("abort_no_eof", out_eof, 0);
          chk("abort_idle", busy, 0);
        end
      end else begin
        chk("frame_done_pulses", dones, 1);
        chk("end_frame_done_low", frame_done, 0);
        chk("output_count", popped, NOUT);
        chk("no_pending_outputs", exp_q.size(), 0);
      end
    end
  endtask

  task automatic load_pattern();
    for (int i = 0; i < FLEN; i++) smp[i] = ((i * 3217) % 9001) - 4500;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < TAPS; k++) coef[k] = (k + 1) * 100;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    reset_outputs_chk("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("idle_fir_rst", fir_rst, 0);
    chk("idle_busy", busy, 0);

    // Basic frame, full throughput
    load_pattern();
    build_exp();
    do_frame(0, 0, 0);

    // Impulse of 0x7FFF at sample 32: outputs 1..32 carry coef[k]*32767>>15 = coef[k]-1
    for (int i = 0; i < FLEN; i++) smp[i] = 0;
    smp[32] = 32767;
    build_exp();
    chk("model_impulse_out0", exp_q[0].d, 0);
    chk("model_impulse_out1", exp_q[1].d, 99);
    chk("model_impulse_out16", exp_q[16].d, 1599);
    chk("model_impulse_out32", exp_q[32].d, 3199);
    do_frame(0, 0, 0);

    // Backpressure: out_ready toggles every cycle
    load_pattern();
    build_exp();
    do_frame(1, 0, 0);

    // Abort at in_cnt=40, then a clean repeat of the first frame
    build_exp();
    do_frame(0, 1, 40);
    build_exp();
    do_frame(0, 0, 0);

    // start while busy is ignored
    build_exp();
    do_frame(0, 3, 10);

    // start+abort together in IDLE: abort wins
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    #1;
    chk("start_abort_idle_busy", busy, 0);
    chk("start_abort_idle_fir_rst", fir_rst, 0);

    // rst late in the frame (FLUSH when the tail is built), then recovery
    build_exp();
    do_frame(0, 2, RST_AT);
    build_exp();
    do_frame(1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
